// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory read port, redirect input, decode handshake, fault status.
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, perf_fetched, perf_stall,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, perf_fetched, perf_stall,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
`else
  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 2-entry instruction queue, redirect handling and sticky illegal-fetch fault.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_1000,
  parameter int          IMEM_WORDS  = 32,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic {RUN, FAULT} state_e;

  localparam logic [1:0]  QFULL     = 2'(QUEUE_DEPTH);
  localparam logic [32:0] PC_LIMIT  = {1'b0, RESET_PC} + 33'(4 * IMEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        fault_q;
  logic [31:0] fault_pc_q;
  logic        pc_legal;
  logic        out_valid_int;
  logic        push, pop, flush, fault_set;

  assign pc_legal      = (pc_q[1:0] == 2'b00) && (pc_q >= RESET_PC) && ({1'b0, pc_q} < PC_LIMIT);
  assign out_valid_int = (state_q == RUN) && (count != 2'd0);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    fault_set = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.redirect_valid) begin
          // Target legality is judged next cycle, once it is the current PC.
          flush = 1'b1;
          pc_d  = bus.redirect_pc;
        end else if (!pc_legal) begin
          state_d   = FAULT;
          fault_set = 1'b1;
          flush     = 1'b1;
        end else begin
          pop  = out_valid_int && bus.out_ready;
          push = (count != QFULL) || pop;
          if (push) pc_d = pc_q + 32'd4;
        end
      end
      FAULT: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        q_instr[i] <= 32'd0;
        q_pc[i]    <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= bus.imem_data;
          q_pc[wr_ptr]    <= pc_q;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
      if (fault_set) begin
        fault_q    <= 1'b1;
        fault_pc_q <= pc_q;
      end
    end
  end

  assign bus.imem_addr = (state_q == FAULT) ? fault_pc_q : pc_q;
  assign bus.out_valid = out_valid_int;
  assign bus.out_instr = q_instr[rd_ptr];
  assign bus.out_pc    = q_pc[rd_ptr];
  assign bus.fault     = fault_q;
  assign bus.fault_pc  = fault_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Both counters stop naturally in FAULT: no pushes and out_valid is low there.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (out_valid_int && !bus.out_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with a queue-based reference model.
// Perf counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC(32'h0000_1000),
    .IMEM_WORDS(32),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] mem [32];
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1080) return mem[a[6:2]];
    return 32'hDEAD_BEEF ^ a;
  endfunction

  always_comb bus.imem_data = mem_word(bus.imem_addr);

  // Reference model state
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_fault;
  logic [31:0] m_fault_pc;
  logic [31:0] m_fetched, m_stall;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && a >= 32'h1000 && a < 32'h1000 + 4 * 32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h1000;
    m_q.delete();
    m_fault = 0;
    m_fault_pc = 0;
    m_fetched = 0;
    m_stall = 0;
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rdy);
    if (m_fault) return;
    if (m_q.size() > 0 && !rdy) m_stall++;
    if (rv) begin
      m_q.delete();
      m_pc = rpc;
    end else if (!legal(m_pc)) begin
      m_fault = 1;
      m_fault_pc = m_pc;
      m_q.delete();
    end else begin
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() < 2) begin
        m_q.push_back({mem_word(m_pc), m_pc});
        m_pc = m_pc + 32'd4;
        m_fetched++;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] head;
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (!m_fault && m_q.size() > 0)});
    if (!m_fault && m_q.size() > 0) begin
      head = m_q[0];
      chk("out_pc", bus.out_pc, head[31:0]);
      chk("out_instr", bus.out_instr, head[63:32]);
    end
    chk("fault", {31'd0, bus.fault}, {31'd0, m_fault});
    chk("fault_pc", bus.fault_pc, m_fault_pc);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", bus.perf_fetched, m_fetched);
    chk("perf_stall", bus.perf_stall, m_stall);
`endif
  endtask

  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    model_step(rv, rpc, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    check_all();
  endtask

  initial begin
    logic [31:0] tgt;
    bit rv, rdy;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    // Streaming with out_ready high
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 1);

    // Back-pressure: queue fills, PC freezes, then drains without bubble
    do_reset();
    cycle(0, 0, 0);
    chk("first_pc", bus.out_pc, 32'h1000);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    chk("hold_pc", bus.out_pc, 32'h1000);
    chk("hold_addr", bus.imem_addr, 32'h1008);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);

    // Redirect with a full queue
    cycle(1, 32'h1010, 1);
    chk("redir_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h1010);
    cycle(0, 0, 1);
    chk("redir_head", bus.out_pc, 32'h1010);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);

    // Misaligned redirect faults; later redirect ignored; reset clears
    cycle(1, 32'h1006, 1);
    cycle(0, 0, 1);
    chk("mis_fault", {31'd0, bus.fault}, 32'd1);
    chk("mis_fault_pc", bus.fault_pc, 32'h1006);
    cycle(1, 32'h1000, 1);
    chk("fault_ignore_addr", bus.imem_addr, 32'h1006);
    cycle(0, 0, 1);
    do_reset();

    // Run off the end of the memory window
    for (int i = 0; i < 36; i++) cycle(0, 0, 1);
    chk("end_fault", {31'd0, bus.fault}, 32'd1);
    chk("end_fault_pc", bus.fault_pc, 32'h1080);

`ifdef FETCH_PERF_EN
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1);
    chk("perf10", bus.perf_fetched, 32'd10);
    chk("perf3", bus.perf_stall, 32'd3);
    do_reset();
    chk("perf_rst_f", bus.perf_fetched, 32'd0);
    chk("perf_rst_s", bus.perf_stall, 32'd0);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        rv  = ($urandom_range(0, 11) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0:       tgt = 32'h1000 + ($urandom_range(0, 127) & 32'h7F);
          1:       tgt = $urandom;
          default: tgt = 32'h1000 + 4 * $urandom_range(0, 31);
        endcase
        cycle(rv, tgt, rdy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
